// File: rtl/gx_rst_seq.sv
// Reset sequencer for one 10GBASE-R transceiver channel and its TX PLL.
// Independent TX and RX state machines gate the PMA/PCS resets on synchronised status.
module gx_rst_seq #(
    parameter int unsigned PLL_PD_CYC  = 50,
    parameter int unsigned TX_LOCK_CYC = 1000,
    parameter int unsigned RX_ANA_CYC  = 2000,
    parameter int unsigned RX_LTD_CYC  = 250,
    parameter int unsigned SYNC_N      = 2
) (
    input  logic clk,
    input  logic rst_i,
    input  logic pll_locked_i,
    input  logic tx_cal_busy_i,
    input  logic rx_cal_busy_i,
    input  logic rx_is_lockedtodata_i,
    output logic pll_powerdown_o,
    output logic tx_analogreset_o,
    output logic tx_digitalreset_o,
    output logic rx_analogreset_o,
    output logic rx_digitalreset_o,
    output logic tx_ready_o,
    output logic rx_ready_o
);

    localparam int unsigned MAX_TX  = (PLL_PD_CYC > TX_LOCK_CYC) ? PLL_PD_CYC : TX_LOCK_CYC;
    localparam int unsigned MAX_RX  = (RX_ANA_CYC > RX_LTD_CYC) ? RX_ANA_CYC : RX_LTD_CYC;
    localparam int unsigned MAX_CYC = (MAX_TX > MAX_RX) ? MAX_TX : MAX_RX;
    localparam int unsigned CW      = $clog2(MAX_CYC + 1);
    localparam int unsigned NSTAT   = 4;

    typedef enum logic [1:0] {TX_PD, TX_ANA, TX_DIG, TX_RDY} tx_st_e;
    typedef enum logic [1:0] {RX_ANA, RX_LTD, RX_RDY} rx_st_e;

    // Saturating increment so a held condition never wraps back to zero.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input int unsigned lim);
        return (v >= CW'(lim)) ? CW'(lim) : v + CW'(1);
    endfunction

    logic [SYNC_N-1:0][NSTAT-1:0] sync_q;
    logic [NSTAT-1:0]             status_a;
    logic pll_locked_s, tx_cal_busy_s, rx_cal_busy_s, rx_is_lockedtodata_s;

    tx_st_e          tx_st, tx_nxt;
    rx_st_e          rx_st, rx_nxt;
    logic [CW-1:0]   tx_cnt, tx_run;
    logic [CW-1:0]   rx_cnt, rx_run;

    logic pll_powerdown_c, tx_analogreset_c, tx_digitalreset_c, tx_ready_c;
    logic rx_analogreset_c, rx_digitalreset_c, rx_ready_c;

    assign status_a = {rx_is_lockedtodata_i, rx_cal_busy_i, tx_cal_busy_i, pll_locked_i};
    assign {rx_is_lockedtodata_s, rx_cal_busy_s, tx_cal_busy_s, pll_locked_s} = sync_q[SYNC_N-1];

    // Status synchroniser chain
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_N-2:0], status_a};
        end
    end

    // State registers; counters clear on every state entry
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            tx_st  <= TX_PD;
            rx_st  <= RX_ANA;
            tx_cnt <= '0;
            rx_cnt <= '0;
        end else begin
            tx_st  <= tx_nxt;
            rx_st  <= rx_nxt;
            tx_cnt <= (tx_nxt != tx_st) ? '0 : tx_run;
            rx_cnt <= (rx_nxt != rx_st) ? '0 : rx_run;
        end
    end

    // TX next state: calibration re-entry takes priority over loss of lock
    always_comb begin
        tx_nxt = tx_st;
        tx_run = '0;
        case (tx_st)
            TX_PD: begin
                tx_run = sat_inc(tx_cnt, PLL_PD_CYC);
                if (tx_run >= CW'(PLL_PD_CYC)) tx_nxt = TX_ANA;
            end
            TX_ANA: begin
                if (!tx_cal_busy_s) tx_nxt = TX_DIG;
            end
            TX_DIG: begin
                tx_run = pll_locked_s ? sat_inc(tx_cnt, TX_LOCK_CYC) : '0;
                if (tx_run >= CW'(TX_LOCK_CYC) && !tx_cal_busy_s) tx_nxt = TX_RDY;
            end
            TX_RDY: begin
                if (tx_cal_busy_s)      tx_nxt = TX_ANA;
                else if (!pll_locked_s) tx_nxt = TX_DIG;
            end
            default: tx_nxt = TX_PD;
        endcase
    end

    // RX next state: the analog hold time elapses even while calibration is busy
    always_comb begin
        rx_nxt = rx_st;
        rx_run = '0;
        case (rx_st)
            RX_ANA: begin
                rx_run = sat_inc(rx_cnt, RX_ANA_CYC);
                if (rx_run >= CW'(RX_ANA_CYC) && !rx_cal_busy_s) rx_nxt = RX_LTD;
            end
            RX_LTD: begin
                rx_run = rx_is_lockedtodata_s ? sat_inc(rx_cnt, RX_LTD_CYC) : '0;
                if (rx_cal_busy_s)                   rx_nxt = RX_ANA;
                else if (rx_run >= CW'(RX_LTD_CYC))  rx_nxt = RX_RDY;
            end
            RX_RDY: begin
                if (rx_cal_busy_s)              rx_nxt = RX_ANA;
                else if (!rx_is_lockedtodata_s) rx_nxt = RX_LTD;
            end
            default: rx_nxt = RX_ANA;
        endcase
    end

    // Output decode from current state
    always_comb begin
        pll_powerdown_c   = 1'b0;
        tx_analogreset_c  = 1'b1;
        tx_digitalreset_c = 1'b1;
        tx_ready_c        = 1'b0;
        rx_analogreset_c  = 1'b1;
        rx_digitalreset_c = 1'b1;
        rx_ready_c        = 1'b0;
        case (tx_st)
            TX_PD:   pll_powerdown_c = 1'b1;
            TX_ANA:  tx_analogreset_c = 1'b1;
            TX_DIG:  tx_analogreset_c = 1'b0;
            TX_RDY: begin
                tx_analogreset_c  = 1'b0;
                tx_digitalreset_c = 1'b0;
                tx_ready_c        = 1'b1;
            end
            default: pll_powerdown_c = 1'b1;
        endcase
        case (rx_st)
            RX_ANA:  rx_analogreset_c = 1'b1;
            RX_LTD:  rx_analogreset_c = 1'b0;
            RX_RDY: begin
                rx_analogreset_c  = 1'b0;
                rx_digitalreset_c = 1'b0;
                rx_ready_c        = 1'b1;
            end
            default: rx_analogreset_c = 1'b1;
        endcase
    end

    // Registered outputs, one cycle behind the state
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            pll_powerdown_o   <= 1'b1;
            tx_analogreset_o  <= 1'b1;
            tx_digitalreset_o <= 1'b1;
            rx_analogreset_o  <= 1'b1;
            rx_digitalreset_o <= 1'b1;
            tx_ready_o        <= 1'b0;
            rx_ready_o        <= 1'b0;
        end else begin
            pll_powerdown_o   <= pll_powerdown_c;
            tx_analogreset_o  <= tx_analogreset_c;
            tx_digitalreset_o <= tx_digitalreset_c;
            rx_analogreset_o  <= rx_analogreset_c;
            rx_digitalreset_o <= rx_digitalreset_c;
            tx_ready_o        <= tx_ready_c;
            rx_ready_o        <= rx_ready_c;
        end
    end

endmodule
